// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch stage. Owns the fetch PC, requests words from instruction memory and buffers one instruction for decode.
//   clk, rst                    : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc : PC change from execute (target low bits forced to 00)
//   imem_req/addr/ack/rdata     : instruction memory req/ack handshake
//   if_valid/if_pc/if_instr     : buffered instruction to decode, accepted when id_ready
//   pc_out                      : current fetch PC
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   input  logic            id_ready,
   output logic [XLEN-1:0] pc_out
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;
   localparam logic [XLEN-1:0] RST_PC = {RESET_PC[XLEN-1:2], 2'b00};
   state_t state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
   logic [XLEN-1:0] rd_pc;
   assign rd_pc     = {redirect_pc[XLEN-1:2], 2'b00};
   assign imem_req  = state_q == FETCH || state_q == FLUSH;
   // A redirect kills the buffered instruction in the same cycle it arrives.
   assign if_valid  = state_q == HOLD && !redirect_valid;
   // In FLUSH pc_q still holds the address of the request in flight.
   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RST_PC;
         pend_pc_q  <= '0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect_valid) pc_d = rd_pc;
         end
         FETCH: begin
            if (imem_ack) begin
               if (redirect_valid) pc_d = rd_pc;
               else begin
                  if_instr_d = imem_rdata;
                  if_pc_d    = pc_q;
                  pc_d       = pc_q + 32'd4;
                  state_d    = HOLD;
               end
            end else if (redirect_valid) begin
               // The request must complete at its old address; remember the target.
               pend_pc_d = rd_pc;
               state_d   = FLUSH;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d    = rd_pc;
               state_d = FETCH;
            end else if (id_ready) state_d = FETCH;
         end
         FLUSH: begin
            if (imem_ack) begin
               pc_d    = redirect_valid ? rd_pc : pend_pc_q;
               state_d = FETCH;
            end else if (redirect_valid) pend_pc_d = rd_pc;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of the fetch stage with two reset PCs.
module tb_instr_fetch_unit;
   logic clk = 0;
   always #5 clk = ~clk;
   int errs = 0, checks = 0;

   logic        rst, redir, idr, zw, ack_man;
   logic [31:0] redir_pc;
   logic        req, ack, ifv;
   logic [31:0] addr, rdata, ifpc, ifins, pco;
   assign ack   = zw ? req : ack_man;
   assign rdata = addr ^ 32'hA5A5_0000;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redir), .redirect_pc(redir_pc),
      .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
      .if_valid(ifv), .if_pc(ifpc), .if_instr(ifins), .id_ready(idr), .pc_out(pco));

   logic        rst_b, ack_en_b;
   logic        req_b, ack_b, ifv_b;
   logic [31:0] addr_b, rdata_b, ifpc_b, ifins_b, pco_b;
   assign ack_b   = req_b & ack_en_b;
   assign rdata_b = addr_b ^ 32'hA5A5_0000;

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut_b (
      .clk(clk), .rst(rst_b), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack_b), .imem_rdata(rdata_b),
      .if_valid(ifv_b), .if_pc(ifpc_b), .if_instr(ifins_b), .id_ready(1'b1), .pc_out(pco_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1; rst_b = 1; redir = 0; redir_pc = 0; idr = 1; zw = 1; ack_man = 0; ack_en_b = 1;
      #3;
      chk("rst_req", {31'b0, req}, 0);
      chk("rst_ifv", {31'b0, ifv}, 0);
      chk("rst_addr", addr, 0);
      chk("rst_pc", pco, 0);
      chk("rst_ifpc", ifpc, 0);
      chk("rst_ifins", ifins, 0);
      #4 rst = 0;
      // zero-wait streaming
      tick();
      chk("first_req", {31'b0, req}, 1);
      chk("first_addr", addr, 0);
      chk("first_ifv", {31'b0, ifv}, 0);
      tick();
      chk("h0_ifv", {31'b0, ifv}, 1);
      chk("h0_ifpc", ifpc, 0);
      chk("h0_ins", ifins, 32'hA5A5_0000);
      chk("h0_req", {31'b0, req}, 0);
      chk("h0_pc", pco, 4);
      tick();
      chk("f4_addr", addr, 4);
      chk("f4_ifv", {31'b0, ifv}, 0);
      tick();
      chk("h4_ifpc", ifpc, 4);
      chk("h4_ins", ifins, 32'hA5A5_0004);
      tick();
      chk("f8_addr", addr, 8);
      tick();
      chk("h8_ifv", {31'b0, ifv}, 1);
      chk("h8_ifpc", ifpc, 8);
      chk("h8_ins", ifins, 32'hA5A5_0008);
      zw = 0;
      // wait-state memory at address C
      tick();
      chk("fc_req", {31'b0, req}, 1);
      chk("fc_addr", addr, 32'hC);
      idr = 0;
      tick();
      chk("wait1_addr", addr, 32'hC);
      chk("wait1_req", {31'b0, req}, 1);
      tick();
      chk("wait2_addr", addr, 32'hC);
      ack_man = 1;
      tick();
      ack_man = 0;
      chk("hc_ifpc", ifpc, 32'hC);
      chk("hc_ins", ifins, 32'hA5A5_000C);
      for (int i = 0; i < 4; i++) begin
         chk("stall_ifv", {31'b0, ifv}, 1);
         chk("stall_ins", ifins, 32'hA5A5_000C);
         chk("stall_req", {31'b0, req}, 0);
         tick();
      end
      chk("stall_end_req", {31'b0, req}, 0);
      idr = 1;
      tick();
      chk("f10_req", {31'b0, req}, 1);
      chk("f10_addr", addr, 32'h10);
      ack_man = 1;
      tick();
      ack_man = 0;
      chk("h10_ifpc", ifpc, 32'h10);
      // redirect in HOLD
      redir = 1; redir_pc = 32'h0000_0103;
      #1;
      chk("hredir_ifv", {31'b0, ifv}, 0);
      tick();
      redir = 0;
      chk("hredir_req", {31'b0, req}, 1);
      chk("hredir_addr", addr, 32'h100);
      chk("hredir_ifpc", ifpc, 32'h10);
      // two redirects while the request at 0x100 is pending
      redir = 1; redir_pc = 32'h200;
      tick();
      chk("fl1_addr", addr, 32'h100);
      chk("fl1_ifv", {31'b0, ifv}, 0);
      redir_pc = 32'h300;
      tick();
      redir = 0;
      chk("fl2_addr", addr, 32'h100);
      tick();
      chk("fl3_req", {31'b0, req}, 1);
      chk("fl3_addr", addr, 32'h100);
      ack_man = 1;
      tick();
      ack_man = 0;
      chk("fl_done_req", {31'b0, req}, 1);
      chk("fl_done_addr", addr, 32'h300);
      chk("fl_done_ifv", {31'b0, ifv}, 0);
      chk("fl_done_ifpc", ifpc, 32'h10);
      // redirect coincident with ack in FETCH
      ack_man = 1; redir = 1; redir_pc = 32'h400;
      tick();
      ack_man = 0; redir = 0;
      chk("coin_req", {31'b0, req}, 1);
      chk("coin_addr", addr, 32'h400);
      chk("coin_ifv", {31'b0, ifv}, 0);
      chk("coin_ins", ifins, 32'hA5A5_0010);
      ack_man = 1;
      tick();
      ack_man = 0;
      chk("h400_ifpc", ifpc, 32'h400);
      chk("h400_ins", ifins, 32'hA5A5_0400);
      // RESET_PC = FFFF_FFFC, wrap and mid-request reset
      chk("b_rst_pc", pco_b, 32'hFFFF_FFFC);
      chk("b_rst_addr", addr_b, 32'hFFFF_FFFC);
      chk("b_rst_req", {31'b0, req_b}, 0);
      rst_b = 0;
      tick();
      chk("b_f_req", {31'b0, req_b}, 1);
      chk("b_f_addr", addr_b, 32'hFFFF_FFFC);
      tick();
      chk("b_h_ifpc", ifpc_b, 32'hFFFF_FFFC);
      chk("b_h_pc", pco_b, 32'h0);
      ack_en_b = 0;
      tick();
      chk("b_wrap_req", {31'b0, req_b}, 1);
      chk("b_wrap_addr", addr_b, 32'h0);
      rst_b = 1;
      #1;
      chk("b_mid_req", {31'b0, req_b}, 0);
      chk("b_mid_pc", pco_b, 32'hFFFF_FFFC);
      chk("b_mid_ifv", {31'b0, ifv_b}, 0);
      rst_b = 0;
      tick();
      chk("b_re_req", {31'b0, req_b}, 1);
      chk("b_re_addr", addr_b, 32'hFFFF_FFFC);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage for the RV32 core. Owns the architectural fetch PC.
- Issues word requests to instruction memory over a req/ack handshake and holds each returned instruction in a one-entry buffer.
- Presents that buffer to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, including while a memory request is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width; only 32 supported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- redirect_valid  input  1  execute requests PC change this cycle
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 00)
- imem_req  output  1  instruction memory request
- imem_addr  output  32  word-aligned fetch address
- imem_ack  input  1  memory completes request this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- if_valid  output  1  buffered instruction available to decode
- if_pc  output  32  PC of buffered instruction
- if_instr  output  32  buffered instruction word
- id_ready  input  1  decode accepts instruction
- pc_out  output  32  current fetch PC register (debug/next-PC view)

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, pc=RESET_PC, pend_pc=0, if_pc=0, if_instr=0.
  - imem_req=0, if_valid=0, imem_addr=RESET_PC, pc_out=RESET_PC.
  - Reset asserted mid-request abandons the request; no ack is tracked afterwards.
- Memory handshake:
  - imem_req and imem_addr stay stable from assertion until the edge where imem_ack=1 is sampled. The request terminates at that edge.
  - imem_rdata is captured only on that edge.
  - imem_ack while imem_req=0 is ignored.
  - Memory may ack in the same cycle as req (zero wait states).
- Decode handshake: transfer occurs on an edge with if_valid=1 and id_ready=1.
- States:
  - IDLE:
    - imem_req=0, if_valid=0.
    - Next cycle → FETCH, so the first request is asserted 1 cycle after reset release.
    - redirect_valid here loads pc<=redirect_pc.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - ack & !redirect_valid: if_instr<=imem_rdata, if_pc<=pc, pc<=pc+4, → HOLD.
    - ack & redirect_valid: data discarded, pc<=redirect_pc, stay FETCH. New request issued next cycle, back-to-back.
    - !ack & redirect_valid: pend_pc<=redirect_pc, → FLUSH. imem_addr keeps the old pc.
    - !ack & !redirect_valid: stay.
  - HOLD:
    - imem_req=0.
    - if_valid = !redirect_valid (combinational), so a redirect kills the buffered instruction in the same cycle.
    - redirect_valid: pc<=redirect_pc, → FETCH. Redirect wins over id_ready, and no transfer occurs.
    - id_ready: → FETCH.
    - else: stay.
  - FLUSH:
    - imem_req=1, imem_addr=old pc, if_valid=0.
    - redirect_valid without ack: pend_pc<=redirect_pc (latest wins).
    - On ack: data discarded; pc<=redirect_pc if redirect_valid that cycle, else pend_pc; → FETCH.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - RESET_PC[1:0] and redirect targets are forced to 00.
- Throughput: max one instruction per 2 cycles (FETCH+HOLD) with zero-wait memory.
- Outputs:
  - imem_req and if_valid are decoded from state; if_valid is additionally gated by redirect_valid.
  - All data outputs are registered.

Test Plan:
- Reset release, zero-wait memory (ack=req, rdata=addr^32'hA5A5_0000), id_ready=1:
  - First imem_req 1 cycle after rst falls.
  - Addresses 0,4,8,C.
  - if_valid pulses every 2nd cycle with if_pc=0,4,8 and matching if_instr.
- Memory wait states (ack 3 cycles after req), id_ready held 0 for 4 cycles:
  - imem_addr stable during the wait.
  - if_valid high and if_instr stable while stalled.
  - No new req until id_ready=1.
- Redirect to 32'h0000_0103 while in HOLD with id_ready=1:
  - if_valid=0 that cycle, no transfer.
  - Next request addr=32'h0000_0100.
- Redirect to 0x200 then 0x300 during a 4-cycle pending ack:
  - Req keeps old address until ack; returned data is never presented.
  - Next request addr=0x300.
- Redirect coincident with ack in FETCH:
  - Data dropped.
  - Next cycle imem_req=1 with addr=redirect target (back-to-back).
- RESET_PC=32'hFFFF_FFFC:
  - Fetch at FFFF_FFFC then 0000_0000.
  - rst asserted mid-request → imem_req=0 immediately and pc_out=RESET_PC.
